hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter DEPTH, default 3: number of tracked post-decode stages; stage 0 = EX, stage DEPTH-1 = WB.
REQ-002 Parameter REGW, default 3: register-select width.
REQ-003 Parameter FWD_EN, default 1: 1 = forwarding enabled, 0 = stall-only operation.
REQ-004 Parameter ALU_RDY, default 0: lowest stage index at which a non-load result is forwardable.
REQ-005 Parameter LOAD_RDY, default 1: lowest stage index at which a load result is forwardable.
REQ-006 Parameter RF_BYPASS, default 1: 1 = the register file writes before it reads, so the entry in stage DEPTH-1 never causes a hazard.
REQ-007 Parameter CNTW, default 16: width of the performance counters.
REQ-008 Derived width: SELW = clog2(DEPTH+1).
REQ-009 Port clk, input, 1: clock; all state updates on the rising edge.
REQ-010 Port rst, input, 1: reset; synchronous, active-high.
REQ-011 Port id_valid, input, 1: the ID stage holds a real instruction.
REQ-012 Port id_rs1, input, REGW, and port id_rs1_use, input, 1: source 1 select and its use flag.
REQ-013 Port id_rs2, input, REGW, and port id_rs2_use, input, 1: source 2 select and its use flag.
REQ-014 Port id_wr, input, 1, and port id_ws, input, REGW: the ID instruction writes register id_ws.
REQ-015 Port id_load, input, 1: the ID instruction is a load.
REQ-016 Port flush, input, 1: branch taken in EX; kills the ID instruction.
REQ-017 Port clr_cnt, input, 1: synchronous clear of both counters.
REQ-018 Port stall, output, 1: hold IF/ID and insert a bubble into EX.
REQ-019 Port fwd_sel1, output, SELW, and port fwd_sel2, output, SELW: operand source; 0 = register file, k+1 = stage k result bus.
REQ-020 Port stall_cnt, output, CNTW, and port flush_cnt, output, CNTW: saturating event counters.

Function
REQ-021 The block SHALL hold a DEPTH-entry shift pipeline; each entry = {valid, wr, ws, load}.
REQ-022 Every cycle, entry k SHALL advance to entry k+1; entry DEPTH-1 SHALL be discarded.
REQ-023 Entry 0 SHALL load {id_valid, id_wr, id_ws, id_load} when id_valid & !stall & !flush; otherwise entry 0 SHALL load a bubble (valid=0).
REQ-024 A match for source n SHALL be: id_rsn_use & entry valid & wr & ws==id_rsn, excluding stage DEPTH-1 when RF_BYPASS=1.
REQ-025 Only the youngest (lowest-index) matching entry SHALL be considered; it shadows all older matches.
REQ-026 A match is ready iff its stage index >= LOAD_RDY (load) or >= ALU_RDY (non-load).
REQ-027 With FWD_EN=1: stall = id_valid & !flush & (either source's youngest match is not ready).
REQ-028 With FWD_EN=1: fwd_seln = k+1 for a ready youngest match in stage k, else 0.
REQ-029 With FWD_EN=0: stall = id_valid & !flush & (any match on either source); fwd_sel1 = fwd_sel2 = 0 always.
REQ-030 stall, fwd_sel1 and fwd_sel2 SHALL be combinational from the current entries and ID inputs; zero added latency.
REQ-031 Whenever stall=1 or flush=1, fwd_sel1 and fwd_sel2 SHALL be 0.
REQ-032 flush SHALL override stall in the same cycle (stall=0) and insert a bubble into entry 0.
REQ-033 stall_cnt SHALL increment on every cycle with stall=1 and hold at all-ones (no wrap).
REQ-034 flush_cnt SHALL increment on every cycle with flush=1 and hold at all-ones (no wrap).
REQ-035 clr_cnt SHALL zero both counters and take priority over a same-cycle increment; it SHALL NOT affect the entries.

Reset
REQ-036 On rst=1 at a clock edge, all entries SHALL become invalid and both counters SHALL become 0.
REQ-037 While rst=1, stall SHALL be 0, fwd_sel1 and fwd_sel2 SHALL be 0, and no entry SHALL be loaded.
REQ-038 rst asserted mid-stall SHALL drop stall on the next cycle; every in-flight entry SHALL be discarded.

Verification (defaults unless stated)
REQ-039 Reset: 1-cycle rst with random inputs -> stall=0, fwd_sel1=0, fwd_sel2=0, stall_cnt=0, flush_cnt=0; entries empty.
REQ-040 ALU-to-ALU: issue wr r3, next cycle rs1=r3 -> stall=0, fwd_sel1=1; one cycle later a consumer of r3 sees fwd_sel1=2.
REQ-041 Load-use: load to r5, next cycle rs2=r5 -> stall=1 for 1 cycle, then fwd_sel2=2; stall_cnt=1.
REQ-042 FWD_EN=0, back-to-back dependency on r1 -> stall for 2 cycles (RF_BYPASS=1) or 3 cycles (RF_BYPASS=0), then fwd_sel1=0.
REQ-043 Shadowing: two consecutive writes to r2, then a consumer -> fwd_sel1=1 (youngest), never 2.
REQ-044 Flush during load-use stall -> same-cycle stall=0 and fwd_sel1=fwd_sel2=0; entry 0 is a bubble next cycle; flush_cnt=1.
REQ-045 CNTW=4, hold a dependency for 20 cycles -> stall_cnt saturates at 15; clr_cnt then gives 0 on the next cycle.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Tracks in-flight register writers behind ID and produces the
// stall, forwarding selects and stall/flush event counters.
module hazard_ctrl #(
  parameter int DEPTH     = 3,
  parameter int REGW      = 3,
  parameter int FWD_EN    = 1,
  parameter int ALU_RDY   = 0,
  parameter int LOAD_RDY  = 1,
  parameter int RF_BYPASS = 1,
  parameter int CNTW      = 16,
  localparam int SELW     = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs1,
  input  logic            id_rs1_use,
  input  logic [REGW-1:0] id_rs2,
  input  logic            id_rs2_use,
  input  logic            id_wr,
  input  logic [REGW-1:0] id_ws,
  input  logic            id_load,
  input  logic            flush,
  input  logic            clr_cnt,
  output logic            stall,
  output logic [SELW-1:0] fwd_sel1,
  output logic [SELW-1:0] fwd_sel2,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  typedef struct packed {
    logic            v;
    logic            wr;
    logic [REGW-1:0] ws;
    logic            ld;
  } ent_t;

  // WB is invisible when the register file writes before it reads
  localparam int LAST = (RF_BYPASS != 0) ? DEPTH - 2 : DEPTH - 1;

  ent_t ent [DEPTH];

  logic            hit1, rdy1;
  logic            hit2, rdy2;
  logic [SELW-1:0] k1, k2;
  logic            act;

  // Scan oldest to youngest so the youngest match wins
  always_comb begin
    hit1 = 1'b0;
    rdy1 = 1'b0;
    k1   = '0;
    hit2 = 1'b0;
    rdy2 = 1'b0;
    k2   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (k <= LAST && id_rs1_use && ent[k].v &&
          ent[k].wr && ent[k].ws == id_rs1) begin
        hit1 = 1'b1;
        k1   = SELW'(k + 1);
        rdy1 = ent[k].ld ? (k >= LOAD_RDY)
                         : (k >= ALU_RDY);
      end
      if (k <= LAST && id_rs2_use && ent[k].v &&
          ent[k].wr && ent[k].ws == id_rs2) begin
        hit2 = 1'b1;
        k2   = SELW'(k + 1);
        rdy2 = ent[k].ld ? (k >= LOAD_RDY)
                         : (k >= ALU_RDY);
      end
    end
  end

  assign act = id_valid & ~flush & ~rst;

  always_comb begin
    stall    = 1'b0;
    fwd_sel1 = '0;
    fwd_sel2 = '0;
    if (FWD_EN != 0) begin
      stall = act & ((hit1 & ~rdy1) | (hit2 & ~rdy2));
      if (!stall && !flush && !rst) begin
        if (hit1 && rdy1) fwd_sel1 = k1;
        if (hit2 && rdy2) fwd_sel2 = k2;
      end
    end else begin
      stall = act & (hit1 | hit2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) ent[k] <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      ent[0] <= {id_valid & ~stall & ~flush,
                 id_wr, id_ws, id_load};
      for (int k = 1; k < DEPTH; k++) ent[k] <= ent[k-1];
      if (clr_cnt) begin
        stall_cnt <= '0;
        flush_cnt <= '0;
      end else begin
        if (stall && stall_cnt != '1)
          stall_cnt <= stall_cnt + CNTW'(1);
        if (flush && flush_cnt != '1)
          flush_cnt <= flush_cnt + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: default, stall-only and
// narrow-counter instances share one stimulus stream.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [2:0] id_rs1, id_rs2, id_ws;
  logic       id_rs1_use, id_rs2_use;
  logic       id_wr, id_load;
  logic       flush, clr_cnt;

  logic        s_d, s_n, s_n0, s_c;
  logic [1:0]  f1_d, f2_d, f1_n, f2_n;
  logic [1:0]  f1_n0, f2_n0, f1_c, f2_c;
  logic [15:0] sc_d, fc_d, sc_n, fc_n, sc_n0, fc_n0;
  logic [3:0]  sc_c, fc_c;

  int tot = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_use(id_rs1_use),
    .id_rs2(id_rs2), .id_rs2_use(id_rs2_use),
    .id_wr(id_wr), .id_ws(id_ws), .id_load(id_load),
    .flush(flush), .clr_cnt(clr_cnt), .stall(s_d),
    .fwd_sel1(f1_d), .fwd_sel2(f2_d),
    .stall_cnt(sc_d), .flush_cnt(fc_d)
  );

  hazard_ctrl #(.FWD_EN(0)) u_nf (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_use(id_rs1_use),
    .id_rs2(id_rs2), .id_rs2_use(id_rs2_use),
    .id_wr(id_wr), .id_ws(id_ws), .id_load(id_load),
    .flush(flush), .clr_cnt(clr_cnt), .stall(s_n),
    .fwd_sel1(f1_n), .fwd_sel2(f2_n),
    .stall_cnt(sc_n), .flush_cnt(fc_n)
  );

  hazard_ctrl #(.FWD_EN(0), .RF_BYPASS(0)) u_nf0 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_use(id_rs1_use),
    .id_rs2(id_rs2), .id_rs2_use(id_rs2_use),
    .id_wr(id_wr), .id_ws(id_ws), .id_load(id_load),
    .flush(flush), .clr_cnt(clr_cnt), .stall(s_n0),
    .fwd_sel1(f1_n0), .fwd_sel2(f2_n0),
    .stall_cnt(sc_n0), .flush_cnt(fc_n0)
  );

  hazard_ctrl #(.CNTW(4)) u_c4 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_use(id_rs1_use),
    .id_rs2(id_rs2), .id_rs2_use(id_rs2_use),
    .id_wr(id_wr), .id_ws(id_ws), .id_load(id_load),
    .flush(flush), .clr_cnt(clr_cnt), .stall(s_c),
    .fwd_sel1(f1_c), .fwd_sel2(f2_c),
    .stall_cnt(sc_c), .flush_cnt(fc_c)
  );

  task automatic drv(input logic v,
                     input logic [2:0] r1, input logic u1,
                     input logic [2:0] r2, input logic u2,
                     input logic w, input logic [2:0] ws,
                     input logic ld);
    id_valid   = v;
    id_rs1     = r1;
    id_rs1_use = u1;
    id_rs2     = r2;
    id_rs2_use = u2;
    id_wr      = w;
    id_ws      = ws;
    id_load    = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    clr_cnt = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drv(1, 0, 0, 0, 0, 1, 4, 1);
    tick();
    rst        = 1'b1;
    id_valid   = 1'b1;
    id_rs1     = 3'd4;
    id_rs1_use = 1'b1;
    id_rs2     = 3'd4;
    id_rs2_use = 1'b1;
    id_wr      = 1'($urandom);
    id_ws      = 3'($urandom);
    id_load    = 1'($urandom);
    flush      = 1'($urandom);
    clr_cnt    = 1'($urandom);
    @(negedge clk);
    tot++;
    if (s_d !== 1'b0) begin
      bad++; $display("FAIL rst_stall got=%0d want=0", s_d);
    end
    tot++;
    if (f1_d !== 2'd0 || f2_d !== 2'd0) begin
      bad++;
      $display("FAIL rst_fwd got=%0d/%0d want=0/0", f1_d, f2_d);
    end
    tick();
    rst = 1'b0;
    flush = 1'b0;
    clr_cnt = 1'b0;
    drv(1, 4, 1, 4, 1, 0, 0, 0);
    @(negedge clk);
    tot++;
    if (s_d !== 1'b0 || f1_d !== 2'd0 || f2_d !== 2'd0) begin
      bad++;
      $display("FAIL rst_empty got=%0d/%0d/%0d want=0/0/0",
               s_d, f1_d, f2_d);
    end
    tot++;
    if (sc_d !== 16'd0 || fc_d !== 16'd0) begin
      bad++;
      $display("FAIL rst_cnt got=%0d/%0d want=0/0", sc_d, fc_d);
    end
    tick();
  endtask

  task automatic test_alu_fwd();
    do_reset();
    drv(1, 0, 0, 0, 0, 1, 3, 0);
    tick();
    drv(1, 3, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    tot++;
    if (s_d !== 1'b0 || f1_d !== 2'd1) begin
      bad++;
      $display("FAIL alu_ex got=%0d/%0d want=0/1", s_d, f1_d);
    end
    tick();
    @(negedge clk);
    tot++;
    if (s_d !== 1'b0 || f1_d !== 2'd2) begin
      bad++;
      $display("FAIL alu_mem got=%0d/%0d want=0/2", s_d, f1_d);
    end
    tick();
    @(negedge clk);
    tot++;
    if (s_d !== 1'b0 || f1_d !== 2'd0) begin
      bad++;
      $display("FAIL alu_wb got=%0d/%0d want=0/0", s_d, f1_d);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    drv(1, 0, 0, 0, 0, 1, 5, 1);
    tick();
    drv(1, 0, 0, 5, 1, 0, 0, 0);
    @(negedge clk);
    tot++;
    if (s_d !== 1'b1 || f2_d !== 2'd0) begin
      bad++;
      $display("FAIL ld_stall got=%0d/%0d want=1/0", s_d, f2_d);
    end
    tick();
    @(negedge clk);
    tot++;
    if (s_d !== 1'b0 || f2_d !== 2'd2) begin
      bad++;
      $display("FAIL ld_fwd got=%0d/%0d want=0/2", s_d, f2_d);
    end
    tot++;
    if (sc_d !== 16'd1) begin
      bad++; $display("FAIL ld_cnt got=%0d want=1", sc_d);
    end
    tick();
  endtask

  task automatic test_no_fwd();
    int n1, n0, nz;
    n1 = 0;
    n0 = 0;
    nz = 0;
    do_reset();
    drv(1, 0, 0, 0, 0, 1, 1, 0);
    tick();
    drv(1, 1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (s_n) n1++;
      if (s_n0) n0++;
      if (f1_n != 2'd0 || f1_n0 != 2'd0) nz++;
      tick();
    end
    tot++;
    if (n1 !== 2) begin
      bad++; $display("FAIL nofwd_byp got=%0d want=2", n1);
    end
    tot++;
    if (n0 !== 3) begin
      bad++; $display("FAIL nofwd_nobyp got=%0d want=3", n0);
    end
    tot++;
    if (nz !== 0) begin
      bad++; $display("FAIL nofwd_sel got=%0d want=0", nz);
    end
  endtask

  task automatic test_shadow();
    do_reset();
    drv(1, 0, 0, 0, 0, 1, 2, 0);
    tick();
    tick();
    drv(1, 2, 1, 2, 1, 0, 0, 0);
    @(negedge clk);
    tot++;
    if (s_d !== 1'b0 || f1_d !== 2'd1 || f2_d !== 2'd1) begin
      bad++;
      $display("FAIL shadow got=%0d/%0d/%0d want=0/1/1",
               s_d, f1_d, f2_d);
    end
    tick();
    do_reset();
    drv(1, 0, 0, 0, 0, 1, 6, 0);
    tick();
    drv(1, 0, 0, 0, 0, 1, 6, 1);
    tick();
    drv(1, 6, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    tot++;
    if (s_d !== 1'b1 || f1_d !== 2'd0) begin
      bad++;
      $display("FAIL shadow_ld got=%0d/%0d want=1/0", s_d, f1_d);
    end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    drv(1, 0, 0, 0, 0, 1, 5, 1);
    tick();
    drv(1, 5, 1, 5, 1, 1, 7, 0);
    @(negedge clk);
    tot++;
    if (s_d !== 1'b1) begin
      bad++; $display("FAIL fl_pre got=%0d want=1", s_d);
    end
    #1;
    flush = 1'b1;
    #1;
    tot++;
    if (s_d !== 1'b0 || f1_d !== 2'd0 || f2_d !== 2'd0) begin
      bad++;
      $display("FAIL fl_same got=%0d/%0d/%0d want=0/0/0",
               s_d, f1_d, f2_d);
    end
    tick();
    flush = 1'b0;
    drv(1, 7, 1, 5, 1, 0, 0, 0);
    @(negedge clk);
    tot++;
    if (s_d !== 1'b0 || f1_d !== 2'd0 || f2_d !== 2'd2) begin
      bad++;
      $display("FAIL fl_bubble got=%0d/%0d/%0d want=0/0/2",
               s_d, f1_d, f2_d);
    end
    tot++;
    if (fc_d !== 16'd1 || sc_d !== 16'd0) begin
      bad++;
      $display("FAIL fl_cnt got=%0d/%0d want=1/0", fc_d, sc_d);
    end
    tick();
  endtask

  task automatic test_saturate();
    int ns;
    ns = 0;
    do_reset();
    drv(1, 5, 1, 0, 0, 1, 5, 1);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (s_c) ns++;
      tick();
    end
    tot++;
    if (ns !== 20) begin
      bad++; $display("FAIL sat_stalls got=%0d want=20", ns);
    end
    @(negedge clk);
    tot++;
    if (sc_c !== 4'd15) begin
      bad++; $display("FAIL sat_c4 got=%0d want=15", sc_c);
    end
    tot++;
    if (sc_d !== 16'd20) begin
      bad++; $display("FAIL sat_c16 got=%0d want=20", sc_d);
    end
    tick();
    clr_cnt = 1'b1;
    @(negedge clk);
    tot++;
    if (s_c !== 1'b1) begin
      bad++; $display("FAIL clr_stall got=%0d want=1", s_c);
    end
    tick();
    clr_cnt = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tot++;
    if (sc_c !== 4'd0 || sc_d !== 16'd0) begin
      bad++;
      $display("FAIL clr got=%0d/%0d want=0/0", sc_c, sc_d);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    clr_cnt = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_no_fwd();
    test_shadow();
    test_flush();
    test_saturate();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
